// File: rtl/hdmi_pkg.sv
// Shared encodings and period lengths for the HDMI period scheduler.
package hdmi_pkg;

  typedef enum logic [2:0] {
    M_CTRL      = 3'd0,
    M_VID_PRE   = 3'd1,
    M_VID_GUARD = 3'd2,
    M_VIDEO     = 3'd3,
    M_ISL_PRE   = 3'd4,
    M_ISL_GUARD = 3'd5,
    M_ISL_DATA  = 3'd6
  } mode_e;

  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_ISL_PRE = 4'b0101;

  localparam int unsigned PRE_LEN   = 8;
  localparam int unsigned GUARD_LEN = 2;
  localparam int unsigned PKT_LEN   = 32;

  typedef struct packed {
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;
  } pix_t;

endpackage

// File: rtl/hdmi_lookahead_delay.sv
// Lookahead window over the pixel stream: slot DEPTH is the live input,
// slot 0 the oldest registered pixel; also reports an all-blank window.
module hdmi_lookahead_delay
  import hdmi_pkg::*;
#(
  parameter int unsigned DEPTH = 66
) (
  input  logic           pixclk,
  input  logic           resetn,
  input  pix_t           pix_in,
  output pix_t           pix_out,
  output logic [DEPTH:0] de_win,
  output logic           win_zero
);

  pix_t sr [DEPTH];

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned j = 0; j < DEPTH; j++) sr[j] <= '0;
    end else begin
      sr[DEPTH-1] <= pix_in;
      for (int unsigned j = 0; j < DEPTH - 1; j++) sr[j] <= sr[j+1];
    end
  end

  always_comb begin
    de_win        = '0;
    de_win[DEPTH] = pix_in.de;
    for (int unsigned j = 0; j < DEPTH; j++) de_win[j] = sr[j].de;
  end

  assign pix_out  = sr[0];
  assign win_zero = ~|de_win;

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Chooses control / video / data-island periods for the delayed TMDS stream
// and sequences data islands inside horizontal blanking.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned NPKT     = 1,
  parameter int unsigned MIN_CTRL = 12
) (
  input  logic        pixclk,
  input  logic        resetn,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [23:0] rgb_i,
  input  logic        pkt_valid,
  output logic        pkt_start,
  output logic        pkt_rd,
  output logic [4:0]  pkt_idx,
  output logic        pkt_num,
  output logic [2:0]  mode,
  output logic [3:0]  ctl,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [23:0] rgb_o
);

  localparam int unsigned D        = 22 + 12*NPKT + 32*NPKT;
  localparam int unsigned DATA_LEN = PKT_LEN * NPKT;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGUARD, S_DATA, S_TGUARD} isl_e;

  isl_e       state;
  logic [5:0] cnt;
  logic [5:0] ctrl_cnt;
  pix_t       slot0;
  logic [D:0] de_win;
  logic       win_zero;
  mode_e      mode_next;
  logic       commit, vid_guard, vid_pre;

  hdmi_lookahead_delay #(.DEPTH(D)) u_delay (
    .pixclk  (pixclk),
    .resetn  (resetn),
    .pix_in  ({de_i, hsync_i, vsync_i, rgb_i}),
    .pix_out (slot0),
    .de_win  (de_win),
    .win_zero(win_zero)
  );

  always_comb begin
    vid_guard = (de_win[1] & ~de_win[0]) | (de_win[2] & ~de_win[1]);
    vid_pre   = 1'b0;
    for (int unsigned k = 3; k <= 10; k++) vid_pre = vid_pre | (de_win[k] & ~de_win[k-1]);
    // A fully blank window guarantees the whole island plus MIN_CTRL fits before video.
    commit = (state == S_IDLE) && pkt_valid && win_zero && (32'(ctrl_cnt) >= MIN_CTRL);
    mode_next = M_CTRL;
    if (de_win[0])      mode_next = M_VIDEO;
    else if (vid_guard) mode_next = M_VID_GUARD;
    else if (vid_pre)   mode_next = M_VID_PRE;
    else begin
      case (state)
        S_PRE:              mode_next = M_ISL_PRE;
        S_LGUARD, S_TGUARD: mode_next = M_ISL_GUARD;
        S_DATA:             mode_next = M_ISL_DATA;
        default:            mode_next = M_CTRL;
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ctrl_cnt  <= '0;
      mode      <= M_CTRL;
      ctl       <= '0;
      pkt_start <= 1'b0;
      pkt_rd    <= 1'b0;
      pkt_idx   <= '0;
      pkt_num   <= 1'b0;
      de_o      <= 1'b0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
      rgb_o     <= '0;
    end else begin
      mode    <= mode_next;
      ctl     <= (mode_next == M_VID_PRE) ? CTL_VID_PRE :
                 (mode_next == M_ISL_PRE) ? CTL_ISL_PRE : '0;
      de_o    <= slot0.de;
      hsync_o <= slot0.hsync;
      vsync_o <= slot0.vsync;
      rgb_o   <= slot0.rgb;
      if (mode_next == M_CTRL) ctrl_cnt <= (ctrl_cnt == 6'd63) ? ctrl_cnt : ctrl_cnt + 6'd1;
      else                     ctrl_cnt <= '0;
      pkt_start <= commit;
      pkt_rd    <= 1'b0;
      pkt_idx   <= '0;
      pkt_num   <= 1'b0;
      case (state)
        S_IDLE: if (commit) begin
          state <= S_PRE;
          cnt   <= '0;
        end
        S_PRE: if (cnt == 6'(PRE_LEN - 1)) begin
          state <= S_LGUARD;
          cnt   <= '0;
        end else cnt <= cnt + 6'd1;
        S_LGUARD: if (cnt == 6'(GUARD_LEN - 1)) begin
          state <= S_DATA;
          cnt   <= '0;
        end else cnt <= cnt + 6'd1;
        S_DATA: begin
          pkt_rd  <= 1'b1;
          pkt_idx <= cnt[4:0];
          pkt_num <= cnt[5];
          if (cnt == 6'(DATA_LEN - 1)) begin
            state <= S_TGUARD;
            cnt   <= '0;
          end else cnt <= cnt + 6'd1;
        end
        S_TGUARD: if (cnt == 6'(GUARD_LEN - 1)) begin
          state <= S_IDLE;
          cnt   <= '0;
        end else cnt <= cnt + 6'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Sequences the TMDS link between control, video-data and data-island periods for the 27 MHz 858×525 HDMI output. It sits between the video timing generator and the three per-channel TMDS encoders. It delays the timing and pixel stream by a fixed lookahead so it can insert preambles and guard bands before active video. It also opens a data island in horizontal blanking whenever a packet is pending and fits.

## Interface
Parameters:
- `NPKT`, 1: packets per data island (1..2).
- `MIN_CTRL`, 12: minimum control-period cycles between any two non-control periods.
- `D`, `22 + 12*NPKT + 32*NPKT`: lookahead depth in pixels. Fixed; not overridable.

Ports:
- `pixclk` in 1: pixel clock. Single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `de_i` in 1: display enable from the timing generator.
- `hsync_i` / `vsync_i` in 1: syncs from the timing generator.
- `rgb_i` in 24: pixel {R,G,B}.
- `pkt_valid` in 1: packet buffer holds ≥ NPKT packets.
- `pkt_start` out 1: one-cycle pulse when an island is committed.
- `pkt_rd` out 1: packet data strobe, high on every island-data cycle.
- `pkt_idx` out 5: word index 0..31 within the current packet.
- `pkt_num` out 1: packet number within the island.
- `mode` out 3: 0 CTRL, 1 VID_PRE, 2 VID_GUARD, 3 VIDEO, 4 ISL_PRE, 5 ISL_GUARD, 6 ISL_DATA.
- `ctl` out 4: CTL3..CTL0 for channels 1/2.
- `de_o` / `hsync_o` / `vsync_o` / `rgb_o` out 1/1/1/24: delayed stream, aligned with `mode`.

## Operation
- Delay line, D+1 deep, carries {de, hsync, vsync, rgb}. Output position t is slot 0; slot k is t+k.
- Priority each cycle (registered into `mode`):
  1. **VIDEO**: when de(t)=1.
  2. **VID_GUARD**: when de(t+1) or de(t+2) is the first de after a 0.
  3. **VID_PRE**: when a de rising edge lies at t+3..t+10.
  4. **Island FSM**.
  5. **CTRL** otherwise.
- `ctl` values:
  - 4'b0001 (CTL0=1) in VID_PRE.
  - 4'b0101 (CTL0=1, CTL2=1) in ISL_PRE.
  - 0 elsewhere.
- Island FSM states: IDLE → PRE(8) → LGUARD(2) → DATA(32·NPKT) → TGUARD(2) → IDLE. ISL_GUARD is used for both LGUARD and TGUARD.
- Island commit happens in IDLE when all of the following hold:
  - pkt_valid=1
  - de(t)=0
  - de is 0 in every slot t..t+D
  - ctrl_cnt ≥ MIN_CTRL
- On commit, `pkt_start` pulses and the first PRE cycle is t+1.
- `ctrl_cnt` counts consecutive CTRL cycles. It clears on any non-CTRL mode and saturates at 63.
- In DATA, `pkt_rd`=1 and `pkt_idx` counts 0..31. `pkt_num` increments when `pkt_idx` wraps.
- Once committed, an island runs to completion regardless of pkt_valid.

## Timing
- Latency from an input pixel to its `*_o`/`mode` is D+1 cycles. All outputs are registered.
- `pkt_rd` leads the encoder: the buffer returns data 1 cycle later, aligned with `mode`=ISL_DATA delayed by 1. The downstream encoder adds that 1-cycle delay to `mode`.
- Reset values:
  - Outputs: `mode`=CTRL, `ctl`=0, `pkt_*`=0, `*_o`=0.
  - Delay line: cleared.
  - FSM: IDLE.
  - `ctrl_cnt`: 0, so no island is possible until MIN_CTRL CTRL cycles have elapsed.
- Reset asserted mid-island: returns to CTRL immediately, with no trailing guard.
- Blanking shorter than 10 cycles: preamble/guard are truncated per the priority list and VIDEO is never delayed.
- If de(t+k) would overlap a running island: cannot occur by the commit rule. The verifier asserts it never happens.

## Structure
- Shared package `hdmi_pkg` holds:
  - the `mode` encodings
  - the CTL preamble constants
  - the preamble length 8, guard length 2, packet length 32
- Sub-module `hdmi_lookahead_delay`: a parameterized D+1 shift register plus the de window-zero reduction. The FSM stays in the top.

## Test plan
- **Reset and idle:** `resetn` low for 5 cycles, de_i=0, pkt_valid=0. Expect `mode`=0 and `ctl`=0 throughout, and `pkt_start` never pulses.
- **Video lead-in:** 858-pixel line with de_i high for pixels 0..639, pkt_valid=0. On the output:
  - 8 cycles of VID_PRE with `ctl`=0001
  - 2 cycles of VID_GUARD
  - VIDEO exactly when `de_o`=1
  - `rgb_o` equals `rgb_i` delayed by D+1
- **Island insertion, NPKT=1:** pkt_valid=1, 218-cycle blanking. Expect:
  - `pkt_start` 12 cycles after `de_o` falls
  - 8 ISL_PRE (`ctl`=0101), 2 ISL_GUARD
  - 32 ISL_DATA with `pkt_idx` 0..31
  - 2 ISL_GUARD, then CTRL
- **Insufficient blanking:** blanking of D−1 cycles with pkt_valid=1. Expect no `pkt_start` and no ISL modes.
- **pkt_valid drops mid-island:** pkt_valid falls during DATA. Expect the island to complete all 32 words.
- **Reset mid-island:** `resetn` pulsed low during DATA. Expect `mode`=0 asynchronously and the next `pkt_start` only after ≥ 12 CTRL cycles.
